sort_job_ctrl: RTL
==================

# sort_job_ctrl

Front-end controller that time-shares one `fsm_sort` engine between `R` requesters. Each requester offers an `N`-element vector on a valid/ready port. Round-robin arbitration picks one request, and the controller captures the winner's vector and holds it stable on the engine input. It then issues a single-cycle start pulse, waits for `done` under a watchdog, and returns the sorted vector on a shared response port tagged with the requester ID.

## Interface
- `R`, 4: number of requesters (2..8)
- `N`, 6: elements per vector; must match the engine's `N`
- `WIDTH`, 8: element width; must match the engine's `WIDTH`
- `TIMEOUT`, 64: maximum cycles in WAIT before an error response
- `clk`  in  1  single clock
- `rst`  in  1  synchronous, active-high reset; also drives the engine's `rst`
- `req_valid`  in  [R]  request pending, one bit per requester
- `req_data`  in  [R][N][WIDTH]  request vectors
- `req_ready`  out  [R]  one-hot; high only in the accepting cycle
- `rsp_valid`  out  1  response available
- `rsp_ready`  in  1  consumer accepts the response
- `rsp_id`  out  $clog2(R)  index of the served requester
- `rsp_data`  out  [N][WIDTH]  sorted vector; all zero on error
- `rsp_err`  out  1  response produced by watchdog expiry
- `srt_start`  out  1  engine start; registered, one-cycle pulse
- `srt_data`  out  [N][WIDTH]  engine `data_in`; held from LAUNCH through WAIT
- `srt_done`  in  1  engine `done` (one-cycle pulse)
- `srt_sorted`  in  [N][WIDTH]  engine `data_sorted`
- `busy`  out  1  state is not IDLE
- `err_count`  out  8  saturating count of watchdog expiries

## Operation
- States: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - If any `req_valid` is set, assert `req_ready[g]` for the round-robin winner `g`.
  - Capture `req_data[g]` into the `srt_data` register and `g` into `rsp_id`.
  - Go to LAUNCH.
- LAUNCH: `srt_start=1` for exactly this cycle; clear the watchdog; go to WAIT.
- WAIT: `srt_start=0`.
  - On `srt_done`: register `srt_sorted` into `rsp_data`, set `rsp_err=0`, go to RESP.
  - Otherwise, when the watchdog reaches `TIMEOUT-1`: `rsp_data=0`, `rsp_err=1`, increment `err_count` (saturating at 255), go to RESP.
- RESP: hold `rsp_valid=1` with `rsp_id`, `rsp_data` and `rsp_err` stable. On `rsp_valid & rsp_ready`, go to IDLE.
- Round-robin pointer:
  - Holds the last granted index.
  - The search starts at pointer+1 and wraps at `R-1` to 0.
  - The pointer updates only on acceptance.
  - Reset value is `R-1`, so requester 0 wins first.
- `srt_done` arriving outside WAIT (a late completion after a timeout) is ignored and produces no response.
- Only one job is in flight. No request is accepted outside IDLE.

## Timing
- Reset values: `req_ready=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_data=0`, `rsp_err=0`, `srt_start=0`, `srt_data=0`, `busy=0`, `err_count=0`, state IDLE, pointer `R-1`.
- Acceptance happens in cycle T.
  - `srt_start` is high in T+1 only.
  - The engine pulses `srt_done` in T+8.
  - `rsp_valid` first rises in T+9.
- `srt_start` is low for at least 8 cycles between pulses, which guarantees the engine's rising-edge detector re-arms.
- `srt_data` is constant from T+1 until the next acceptance. The engine samples it in its CALC and PLACE cycles.
- With `rsp_ready` held high, the response completes in T+9 and IDLE returns in T+10. The earliest next acceptance is T+10, giving a throughput of 1 job per 10 cycles.
- Timeout response: `rsp_valid` rises `TIMEOUT+2` cycles after acceptance.
- `rsp_ready` low in RESP stalls indefinitely with all response outputs stable. `req_ready` stays 0 throughout.
- A requester dropping `req_valid` in a non-IDLE cycle has no effect. Only the IDLE-cycle sample counts.
- Reset mid-job:
  - Everything returns to reset values on the next edge, including `err_count`.
  - No response is emitted for the aborted job.
  - The engine resets on the same `rst`.

## Structure
- Package `sort_ctrl_pkg` holds:
  - `ctrl_state_t` (IDLE, LAUNCH, WAIT, RESP)
  - the `ERR_CNT_W=8` localparam
  - the helper function `rr_next(ptr, req)` returning the winner index
- Sub-module `rr_arbiter` #(R): inputs `req[R]`, `ptr`, `en`. Outputs one-hot `gnt`, `gnt_idx`, and updated `ptr`.
- `sort_job_ctrl` instantiates `rr_arbiter` only. `fsm_sort` is instantiated beside it in the enclosing level.

## Test plan
- Single job:
  - Stimulus: requester 2 sends {5,3,9,1,7,2} with `rsp_ready=1`.
  - Response: `req_ready[2]` in cycle T, `srt_start` in T+1 only, `rsp_valid` in T+9 with `rsp_id=2`, `rsp_data={1,2,3,5,7,9}`, `rsp_err=0`.
- Round-robin fairness:
  - Stimulus: all 4 requesters valid continuously.
  - Response: grants go 0,1,2,3,0 with 10-cycle spacing. Releasing requester 1 before its turn yields 0,2,3,0.
- Backpressure:
  - Stimulus: hold `rsp_ready=0` for 20 cycles in RESP.
  - Response: `rsp_*` stable, `req_ready` stays 0; IDLE is entered the cycle after `rsp_ready` rises.
- Watchdog:
  - Stimulus: engine model never asserts `srt_done`, `TIMEOUT=16`.
  - Response: `rsp_valid` 18 cycles after acceptance with `rsp_err=1`, `rsp_data=0`, `err_count=1`. A late `srt_done` in IDLE produces no response.
- Reset mid-job:
  - Stimulus: assert `rst` in WAIT.
  - Response: next cycle `busy=0`, `srt_start=0`, `rsp_valid=0`, pointer `R-1`; the next request from requester 3 alongside 0 grants 0.
- Duplicates:
  - Stimulus: requester 0 sends {4,4,4,4,4,4}.
  - Response: `rsp_data` all 4; `srt_data` is unchanged throughout WAIT.

Source files
------------

// File: rtl/sort_job_ctrl_pkg.sv
// Shared types and helpers for the sort job controller: FSM state encoding,
// error-counter width and the round-robin winner search.
package sort_ctrl_pkg;

  localparam int unsigned ERR_CNT_W = 8;

  // Widest supported requester set; narrower sets are zero-padded up to this.
  localparam int unsigned MAX_R     = 8;
  localparam int unsigned MAX_IDX_W = 3;

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StWait,
    StResp
  } ctrl_state_t;

  // Returns the first set request at or after ptr+1, wrapping to 0. Positions
  // at or above the real requester count are zero, so the wrap at MAX_R-1 gives
  // the same order as a wrap at R-1. With no request set, ptr is returned.
  function automatic logic [MAX_IDX_W-1:0] rr_next(input logic [MAX_IDX_W-1:0] ptr,
                                                   input logic [MAX_R-1:0]     req);
    logic [MAX_IDX_W-1:0] idx;
    rr_next = ptr;
    // Walk from the furthest offset down so the nearest request wins last.
    for (int i = MAX_R; i >= 1; i--) begin
      idx = ptr + MAX_IDX_W'(i);
      if (req[idx]) begin
        rr_next = idx;
      end
    end
  endfunction

endpackage

// File: rtl/sort_job_ctrl_if.sv
// Request, response and engine-side signals of the sort job controller.
// The controller uses the slave modport; its environment uses master.
interface sort_job_ctrl_if #(
  parameter int unsigned R     = 4,
  parameter int unsigned N     = 6,
  parameter int unsigned WIDTH = 8
);

  localparam int unsigned IdW = $clog2(R);

  logic [R-1:0]                      req_valid;
  logic [R-1:0][N-1:0][WIDTH-1:0]    req_data;
  logic [R-1:0]                      req_ready;

  logic                              rsp_valid;
  logic                              rsp_ready;
  logic [IdW-1:0]                    rsp_id;
  logic [N-1:0][WIDTH-1:0]           rsp_data;
  logic                              rsp_err;

  logic                              srt_start;
  logic [N-1:0][WIDTH-1:0]           srt_data;
  logic                              srt_done;
  logic [N-1:0][WIDTH-1:0]           srt_sorted;

  modport slave (
    input  req_valid, req_data, rsp_ready, srt_done, srt_sorted,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, srt_start, srt_data
  );

  modport master (
    output req_valid, req_data, rsp_ready, srt_done, srt_sorted,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, srt_start, srt_data
  );

endinterface

// File: rtl/sort_job_ctrl_rr_arbiter.sv
// Round-robin arbiter: searches from ptr+1 with wrap-around and reports a
// one-hot grant, its index and the pointer value to adopt on acceptance.
module rr_arbiter
  import sort_ctrl_pkg::*;
#(
  parameter int unsigned R = 4
) (
  input  logic [R-1:0]          req,
  input  logic [$clog2(R)-1:0]  ptr,
  input  logic                  en,
  output logic [R-1:0]          gnt,
  output logic [$clog2(R)-1:0]  gnt_idx,
  output logic [$clog2(R)-1:0]  ptr_nxt
);

  localparam int unsigned IdxW = $clog2(R);

  logic [MAX_R-1:0]     req_pad;
  logic [MAX_IDX_W-1:0] win;

  assign req_pad = MAX_R'(req);
  assign win     = rr_next(MAX_IDX_W'(ptr), req_pad);

  // The winner is always below R; decode it back to the local index width.
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < R; i++) begin
      if (win == MAX_IDX_W'(i)) begin
        gnt_idx = IdxW'(i);
      end
    end
  end

  always_comb begin
    gnt     = '0;
    ptr_nxt = ptr;
    if (en && (|req)) begin
      gnt[gnt_idx] = 1'b1;
      ptr_nxt      = gnt_idx;
    end
  end

endmodule

// File: rtl/sort_job_ctrl.sv
// Time-shares one sort engine between R requesters: arbitrates, launches the
// engine with a held vector, waits under a watchdog and returns a tagged result.
module sort_job_ctrl
  import sort_ctrl_pkg::*;
#(
  parameter int unsigned R       = 4,
  parameter int unsigned N       = 6,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  sort_job_ctrl_if.slave       bus,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int unsigned IdxW = $clog2(R);
  localparam int unsigned WdW  = $clog2(TIMEOUT);

  typedef logic [N-1:0][WIDTH-1:0] vec_t;

  ctrl_state_t          state_q, state_d;
  logic [IdxW-1:0]      ptr_q, ptr_nxt, gnt_idx;
  logic [R-1:0]         gnt;
  logic                 arb_en;
  logic                 accept;
  logic                 wd_expire;
  logic [WdW-1:0]       wd_q;

  logic                 srt_start_q;
  vec_t                 srt_data_q;
  logic [IdxW-1:0]      rsp_id_q;
  vec_t                 rsp_data_q;
  logic                 rsp_err_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  rr_arbiter #(
    .R(R)
  ) u_arb (
    .req     (bus.req_valid),
    .ptr     (ptr_q),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .ptr_nxt (ptr_nxt)
  );

  assign accept    = |gnt;
  assign wd_expire = (wd_q == WdW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    arb_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        arb_en = 1'b1;
        if (|bus.req_valid) begin
          state_d = StLaunch;
        end
      end
      StLaunch: begin
        state_d = StWait;
      end
      StWait: begin
        if (bus.srt_done || wd_expire) begin
          state_d = StResp;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= IdxW'(R - 1);
      srt_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      // Acceptance only happens in IDLE, so this is a one-cycle pulse in LAUNCH.
      srt_start_q <= accept;
      if (accept) begin
        ptr_q <= ptr_nxt;
      end
    end
  end

  // The engine input and the response tag stay put until the next acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      srt_data_q <= '0;
      rsp_id_q   <= '0;
    end else if (accept) begin
      srt_data_q <= bus.req_data[gnt_idx];
      rsp_id_q   <= gnt_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q <= '0;
    end else if (state_q == StLaunch) begin
      wd_q <= '0;
    end else if (state_q == StWait) begin
      wd_q <= wd_q + WdW'(1);
    end
  end

  // A done pulse takes priority over a watchdog expiry in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      err_cnt_q  <= '0;
    end else if (state_q == StWait) begin
      if (bus.srt_done) begin
        rsp_data_q <= bus.srt_sorted;
        rsp_err_q  <= 1'b0;
      end else if (wd_expire) begin
        rsp_data_q <= '0;
        rsp_err_q  <= 1'b1;
        if (err_cnt_q != '1) begin
          err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
        end
      end
    end
  end

  assign bus.req_ready = gnt;
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.srt_start = srt_start_q;
  assign bus.srt_data  = srt_data_q;
  assign busy          = (state_q != StIdle);
  assign err_count     = err_cnt_q;

endmodule
